// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Arbitrates the single register-file write port between NREQ writeback
// sources. It uses round-robin order and a valid/grant handshake. The grant is
// combinational. The resulting write command (wr_en/wr_addr/wr_data) is
// registered on the rising edge, so it is stable half a cycle before the
// falling-edge register file captures it.
//
// Ports
//   clk         in   clock; all state updates on the rising edge
//   reset       in   asynchronous active-low reset (0 = in reset)
//   hold        in   1 = issue no grants (pipeline freeze)
//   req         in   [NREQ]         per-requester write request, held until granted
//   req_addr    in   [NREQ*ADDR_W]  requester i address at [i*ADDR_W +: ADDR_W]
//   req_data    in   [NREQ*DATA_W]  requester i data at [i*DATA_W +: DATA_W]
//   gnt         out  [NREQ]         one-hot grant, same cycle as the transfer
//   wr_en       out  registered write enable (suppressed for register 0)
//   wr_addr     out  [ADDR_W]       registered write address
//   wr_data     out  [DATA_W]       registered write data
//   contention  out  registered; 1 after a transfer cycle with >= 2 requests
//   grant_cnt   out  [16]           registered count of transfers, wraps
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hold,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     contention,
  output logic [15:0]              grant_cnt
);

  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0]  rr_ptr_q;
  logic [PTR_W-1:0]  rr_ptr_d;
  logic [PTR_W-1:0]  gnt_idx;
  logic              transfer;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              contention_q;
  logic [15:0]       grant_cnt_q;
  logic [ADDR_W-1:0] sel_addr;

  // Round-robin search starting at rr_ptr_q. The grant is gated by reset, so
  // gnt stays 0 while reset is asserted, whatever req is doing.
  always_comb begin
    // NOTE: every output of this block gets a default first. Otherwise a path
    // that skips the assignment would infer a latch.
    gnt      = '0;
    gnt_idx  = '0;
    transfer = 1'b0;
    if (reset && !hold) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!transfer && req[(int'(rr_ptr_q) + k) % NREQ]) begin
          transfer = 1'b1;
          gnt_idx  = PTR_W'((int'(rr_ptr_q) + k) % NREQ);
          gnt[(int'(rr_ptr_q) + k) % NREQ] = 1'b1;
        end
      end
    end
  end

  // After a grant to i the search starts at i+1, wrapping modulo NREQ.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (transfer) begin
      rr_ptr_d = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  assign sel_addr = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the pre-edge values, whatever order the lines are in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q     <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      contention_q <= 1'b0;
      grant_cnt_q  <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      contention_q <= transfer && ($countones(req) >= 2);
      if (transfer) begin
        // A write to register 0 is still accepted and counted. It is never
        // presented to the register file.
        wr_en_q     <= (sel_addr != '0);
        wr_addr_q   <= sel_addr;
        wr_data_q   <= req_data[int'(gnt_idx)*DATA_W +: DATA_W];
        grant_cnt_q <= grant_cnt_q + 16'd1;
      end else begin
        wr_en_q <= 1'b0;
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign contention = contention_q;
  assign grant_cnt  = grant_cnt_q;

endmodule
